// File: rtl/up_counter.sv
// Free-running binary up-counter with a configurable step, initial value and modulus.
// Provides the registered count and a terminal-count flag for the last value before wrap.
module up_counter #(
    parameter int unsigned     G_WIDTH   = 8,
    parameter longint unsigned G_STEP    = 1,
    parameter longint unsigned G_INIT    = 0,
    parameter longint unsigned G_MODULUS = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [G_WIDTH-1:0] out,
    output logic               tc
);

    localparam int unsigned SW = G_WIDTH + 1;

    // A zero modulus selects the natural 2**G_WIDTH rollover.
    localparam logic [SW-1:0]      MOD      = (G_MODULUS == 64'd0) ? (SW'(1) << G_WIDTH)
                                                                    : SW'(G_MODULUS);
    localparam logic [SW-1:0]      STEP_EXT = SW'(G_STEP);
    localparam logic [G_WIDTH-1:0] INIT_VAL = G_WIDTH'(G_INIT);

    logic [G_WIDTH-1:0] cnt;
    logic [SW-1:0]      sum_c;
    logic               wrap_c;
    logic [G_WIDTH-1:0] next_c;

    // One extra bit on the sum keeps the wrap compare free of overflow.
    always_comb begin
        sum_c  = {1'b0, cnt} + STEP_EXT;
        wrap_c = (sum_c >= MOD);
        next_c = wrap_c ? G_WIDTH'(sum_c - MOD) : G_WIDTH'(sum_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= INIT_VAL;
        end else begin
            cnt <= next_c;
        end
    end

    assign out = cnt;
    assign tc  = wrap_c;

endmodule

// File: tb/tb_up_counter.sv
// Randomized self-checking bench for up_counter: four parameterizations compared every
// cycle against a modular-arithmetic reference, plus fixed timing checks.
`timescale 1ns/1ps
module tb_up_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] o4, o10, o3;
    logic [7:0] o8;
    logic       tc4, tc10, tc3, tc8;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference: index 0 = W4 default, 1 = W4 mod 10, 2 = W4 step 3 init 2, 3 = all defaults
    longint step_p [4] = '{1, 1, 3, 1};
    longint mod_p  [4] = '{16, 10, 16, 256};
    longint init_p [4] = '{0, 0, 2, 0};
    longint exp_v  [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    up_counter #(.G_WIDTH(4)) u4 (.clk(clk), .reset(reset), .out(o4), .tc(tc4));
    up_counter #(.G_WIDTH(4), .G_MODULUS(10)) u10 (.clk(clk), .reset(reset), .out(o10), .tc(tc10));
    up_counter #(.G_WIDTH(4), .G_STEP(3), .G_INIT(2)) u3 (.clk(clk), .reset(reset), .out(o3), .tc(tc3));
    up_counter u8 (.clk(clk), .reset(reset), .out(o8), .tc(tc8));

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) exp_v[i] = init_p[i];
            else       exp_v[i] = (exp_v[i] + step_p[i]) % mod_p[i];
        end
    end

    function automatic logic [63:0] exp_tc(input int i);
        return 64'((exp_v[i] + step_p[i]) >= mod_p[i]);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic at(input longint t);
        #(t - $time);
    endtask

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_w4",   64'(o4),   64'(exp_v[0])); check("tc_w4",   64'(tc4),  exp_tc(0));
            check("out_m10",  64'(o10),  64'(exp_v[1])); check("tc_m10",  64'(tc10), exp_tc(1));
            check("out_s3",   64'(o3),   64'(exp_v[2])); check("tc_s3",   64'(tc3),  exp_tc(2));
            check("out_dflt", 64'(o8),   64'(exp_v[3])); check("tc_dflt", 64'(tc8),  exp_tc(3));
        end
    end

    initial begin
        reset = 1'b0;
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Async reset mid-count and release between edges
        at(6);   check("p1_out_5ns",  64'(o4), 64'd1);
        at(16);  check("p1_out_15ns", 64'(o4), 64'd2);
        at(17);  reset = 1'b1;
        at(18);  check("p1_async_clr", 64'(o4), 64'd0);
        at(26);  check("p1_hold_25ns", 64'(o4), 64'd0);
        at(28);  reset = 1'b0;
        at(36);  check("p1_out_35ns", 64'(o4), 64'd1);
        at(46);  check("p1_out_45ns", 64'(o4), 64'd2);
        at(56);  check("p1_out_55ns", 64'(o4), 64'd3);

        // Second pulse; async load of non-zero init
        at(57);  reset = 1'b1;
        at(58);  check("p2_async_w4", 64'(o4), 64'd0);
                 check("p2_async_s3", 64'(o3), 64'd2);
        at(68);  reset = 1'b0;
        at(76);  check("p2_out_75ns", 64'(o4), 64'd1);
                 check("s3_5",        64'(o3), 64'd5);
        at(86);  check("s3_8",        64'(o3), 64'd8);
        at(96);  check("s3_11",       64'(o3), 64'd11);
                 check("s3_tc_11",    64'(tc3), 64'd0);
        at(106); check("s3_14",       64'(o3), 64'd14);
                 check("s3_tc_14",    64'(tc3), 64'd1);
        at(116); check("s3_wrap_1",   64'(o3), 64'd1);
                 check("s3_tc_1",     64'(tc3), 64'd0);
        at(156); check("m10_9",       64'(o10), 64'd9);
                 check("m10_tc_9",    64'(tc10), 64'd1);
        at(166); check("p2_out_165ns", 64'(o4), 64'd10);
                 check("m10_wrap_0",  64'(o10), 64'd0);
                 check("m10_tc_0",    64'(tc10), 64'd0);

        // Natural rollover 15 -> 0
        at(216); check("w4_15",       64'(o4), 64'd15);
                 check("w4_tc_15",    64'(tc4), 64'd1);
        at(226); check("w4_wrap_0",   64'(o4), 64'd0);
                 check("w4_tc_0",     64'(tc4), 64'd0);
        at(236); check("w4_1",        64'(o4), 64'd1);

        // Reset coincident with a rising edge while the count is 7
        at(296); check("edge_pre_7",  64'(o4), 64'd7);
        at(305); reset = 1'b1;
        at(306); check("edge_rst_not8", 64'(o4), 64'd0);
        at(316); check("edge_rst_hold", 64'(o4), 64'd0);
        at(318); reset = 1'b0;
        at(326); check("edge_rst_rel",  64'(o4), 64'd1);

        // Random reset pulses, asserted and released between edges
        @(posedge clk);
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) begin
                #($urandom_range(1, 2));
                reset = 1'b1;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #($urandom_range(1, 2));
                reset = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
